// File: rtl/an_encoder_seq.sv
// Sequential AN-code encoder: ANc = A * N, computed by
// one shift-and-add step per bit of A behind valid/ready handshakes.
module an_encoder_seq #(
    parameter int A    = 13,
    parameter int A_W  = 4,
    parameter int N_W  = 8,
    parameter int AN_W = 12
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N_W-1:0]  N,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [AN_W-1:0] ANc,
    output logic            busy
);
    localparam int CW = (A_W > 1) ? $clog2(A_W) : 1;
    localparam logic [A_W-1:0] A_BITS = A_W'(A);
    localparam logic [CW-1:0] LAST = CW'(A_W - 1);

    if ((A % 2 == 0) || (A <= 1)) begin : g_bad_a
        $error("an_encoder_seq: A must be odd and greater than 1");
    end

    // The largest product must fit the codeword so the adder never wraps.
    if (((longint'(1) << N_W) - 1) * A >= (longint'(1) << AN_W)) begin : g_bad_w
        $error("an_encoder_seq: AN_W too narrow for (2^N_W-1)*A");
    end

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } state_t;

    state_t          state;
    logic [AN_W-1:0] acc;
    logic [AN_W-1:0] n_reg;
    logic [CW-1:0]   cnt;
    logic            accept;

    assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);
    assign busy      = (state == MUL);
    assign ANc       = acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            n_reg <= '0;
            cnt   <= '0;
        end else if (accept) begin
            n_reg <= AN_W'(N);
            acc   <= '0;
            cnt   <= '0;
            state <= MUL;
        end else begin
            unique case (state)
                MUL: begin
                    if (A_BITS[cnt]) begin
                        acc <= acc + (n_reg << cnt);
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_an_encoder_seq.sv
// Self-checking bench for an_encoder_seq: behavioural
// word-level model, directed cases and randomized traffic.
module tb_an_encoder_seq;
    localparam int A    = 13;
    localparam int A_W  = 4;
    localparam int N_W  = 8;
    localparam int AN_W = 12;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [N_W-1:0]  N;
    logic            out_valid;
    logic            out_ready;
    logic [AN_W-1:0] ANc;
    logic            busy;

    an_encoder_seq #(.A(A), .A_W(A_W), .N_W(N_W), .AN_W(AN_W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .N(N),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .ANc(ANc),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Word-level model: a word occupies the block for A_W edges,
    // then waits as a finished product A*n until drained.
    bit have = 1'b0;
    int age = 0;
    int mn = 0;

    always @(posedge clk or negedge rst_n) begin
        bit mv, mr, acc_ok, hs;
        if (!rst_n) begin
            have = 1'b0;
            age  = 0;
        end else begin
            mv     = have && (age >= A_W);
            mr     = !have || (mv && out_ready);
            acc_ok = in_valid && mr;
            hs     = mv && out_ready;
            if (hs) have = 1'b0;
            if (acc_ok) begin
                have = 1'b1;
                mn   = int'(N);
                age  = 0;
            end else if (have && age < A_W) begin
                age++;
            end
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        bit ev, eb, er;
        ev = have && (age >= A_W);
        eb = have && (age < A_W);
        er = !have || (ev && out_ready);
        chk("out_valid", int'(out_valid), int'(ev));
        chk("busy", int'(busy), int'(eb));
        chk("in_ready", int'(in_ready), int'(er));
        if (!rst_n) chk("ANc_reset", int'(ANc), 0);
        if (ev) begin
            chk("ANc_model", int'(ANc), A * mn);
            chk("ANc_mod_A", int'(ANc) % A, 0);
            chk("decode_roundtrip", int'(ANc) / A, mn);
        end
    end

    // Transaction log: events that will occur at the next rising edge.
    int cyc = 0;
    int got_q[$];
    int hs_edge[$];
    int acc_edge[$];
    int acc_n[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                got_q.push_back(int'(ANc));
                hs_edge.push_back(cyc);
            end
            if (in_valid && in_ready) begin
                acc_edge.push_back(cyc);
                acc_n.push_back(int'(N));
            end
        end
    end

    task automatic do_word(input int n, output int lat, output int bcnt, output int val);
        int t;
        @(posedge clk);
        #1;
        N = N_W'(n);
        in_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("accept_timeout", t, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        bcnt = 0;
        do begin
            @(negedge clk);
            lat++;
            if (busy) bcnt++;
        end while (!out_valid && lat < 50);
        val = int'(ANc);
    endtask

    initial begin
        int lat, bcnt, val, q0, a0, h0, t;
        int vin[4];
        int vexp[4];
        int bb[3];
        vin  = '{0, 1, 252, 255};
        vexp = '{0, 13, 3276, 3315};
        bb   = '{7, 8, 9};

        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        N = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ANc", int'(ANc), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Literal values, latency and busy length
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            do_word(vin[i], lat, bcnt, val);
            chk($sformatf("value_N%0d", vin[i]), val, vexp[i]);
            chk("latency_edges", lat - 1, A_W);
            chk("busy_cycles", bcnt, A_W);
        end

        // Back-pressure
        @(posedge clk);
        #1 out_ready = 1'b0;
        do_word(100, lat, bcnt, val);
        q0 = got_q.size();
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            chk("bp_ANc_stable", int'(ANc), 1300);
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_out_valid", int'(out_valid), 1);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("bp_single_hs", got_q.size() - q0, 1);
        if (got_q.size() > q0) chk("bp_hs_value", got_q[q0], 1300);
        chk("bp_drained", int'(out_valid), 0);

        // Back-to-back
        a0 = acc_edge.size();
        h0 = got_q.size();
        @(posedge clk);
        #1 in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            N = N_W'(bb[i]);
            t = 0;
            @(negedge clk);
            while (!in_ready && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (t >= 50) chk("b2b_accept_timeout", t, 0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("b2b_count", got_q.size() - h0, 3);
        if (got_q.size() >= h0 + 3 && acc_edge.size() >= a0 + 3) begin
            chk("b2b_out0", got_q[h0], 91);
            chk("b2b_out1", got_q[h0 + 1], 104);
            chk("b2b_out2", got_q[h0 + 2], 117);
            chk("b2b_spacing01", acc_edge[a0 + 1] - acc_edge[a0], A_W + 1);
            chk("b2b_spacing12", acc_edge[a0 + 2] - acc_edge[a0 + 1], A_W + 1);
            chk("b2b_accept_on_drain", acc_edge[a0 + 1], hs_edge[h0]);
        end

        // Reset during the second multiply cycle
        @(posedge clk);
        #1;
        N = 8'd200;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", int'(out_valid), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_in_ready", int'(in_ready), 1);
        chk("mid_rst_ANc", int'(ANc), 0);
        q0 = got_q.size();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("mid_rst_no_output", got_q.size() - q0, 0);
        do_word(3, lat, bcnt, val);
        chk("after_rst_N3", val, 39);

        // in_valid pulse during multiply is ignored
        @(posedge clk);
        #1;
        N = 8'd10;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        q0 = got_q.size();
        a0 = acc_edge.size();
        @(posedge clk);
        #1;
        N = 8'd50;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("proto_outputs", got_q.size() - q0, 1);
        if (got_q.size() > q0) chk("proto_value", got_q[q0], 130);
        chk("proto_no_accept", acc_edge.size() - a0, 0);

        // Randomized traffic with output stalls
        a0 = acc_edge.size();
        h0 = got_q.size();
        t = 0;
        while (acc_edge.size() - a0 < 1000 && t < 40000) begin
            @(posedge clk);
            #1;
            in_valid  = ($urandom % 4) != 0;
            N         = N_W'($urandom_range(0, 255));
            out_ready = ($urandom % 3) != 0;
            t++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("rand_accepts", acc_edge.size() - a0, 1000);
        chk("rand_drained", got_q.size() - h0, acc_edge.size() - a0);
        for (int i = 0; i < 1000; i++) begin
            if (h0 + i < got_q.size() && a0 + i < acc_n.size()) begin
                chk("rand_order", got_q[h0 + i], A * acc_n[a0 + i]);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/an_encoder_seq.md
# an_encoder_seq

Sequential AN-code encoder: accepts an N_W-bit data word N and produces the AN_W-bit codeword A·N using a shift-and-add multiplier that runs one multiplier bit of A per cycle. It sits directly upstream of the AN decoder: its codeword output, after any channel or fault injection, becomes the decoder's ANe input. Input and output use valid/ready handshakes so the block can be stalled by the channel model or the decoder side.

## Interface
- A, 13: AN-code constant; must be odd and > 1.
- A_W, 4: bit width of A; equals the number of multiply cycles.
- N_W, 8: data word width.
- AN_W, 12: codeword width; elaboration must fail unless (2^N_W − 1)·A < 2^AN_W.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  N is valid.
- in_ready  out  1  block can accept N this cycle.
- N  in  N_W  data word to encode.
- out_valid  out  1  ANc holds a finished codeword.
- out_ready  in  1  consumer takes ANc this cycle.
- ANc  out  AN_W  codeword A·N.
- busy  out  1  multiply in progress (state MUL).

## Operation
- FSM states: IDLE, MUL, DONE. Reset state is IDLE.
- in_ready = (state == IDLE) || (state == DONE && out_ready). This is combinational from state and out_ready.
- Accept: in_valid && in_ready at a clock edge. On accept:
  - n_reg <= N (zero-extended to AN_W).
  - acc <= 0.
  - cnt <= 0.
  - state <= MUL.
- MUL, each cycle:
  - If A[cnt] is set, acc <= acc + (n_reg << cnt). Otherwise acc is held.
  - cnt <= cnt + 1.
  - When cnt == A_W−1, state <= DONE.
- Arithmetic: the accumulator is AN_W bits with unsigned addition. No overflow is possible under the elaboration check, so no overflow handling is required.
- ANc is driven from acc. out_valid = (state == DONE).
- DONE transitions:
  - Handshake (out_ready high) without a new accept → IDLE.
  - Handshake with a new accept in the same cycle → MUL, and the new operand is loaded as described under Accept.
  - No handshake → stay in DONE. ANc must be held bit-stable.
- In MUL, in_valid is ignored and N is not sampled. out_ready has no effect outside DONE.
- Reset, asynchronous, at any time including mid-multiply: state → IDLE; acc, n_reg and cnt → 0. Any in-flight word is discarded with no output.

## Timing
- Reset values:
  - in_ready = 1 (IDLE).
  - out_valid = 0.
  - busy = 0.
  - ANc = 0.
- Latency: accept at edge E0 → out_valid high in the cycle following edge E0+A_W. With defaults, out_valid rises 4 edges after the accept edge.
- Throughput: one word per A_W+1 cycles when the output is drained immediately and the next word is accepted in the DONE cycle. That is one word per 5 cycles with defaults.
- busy is high for exactly A_W cycles per word.
- ANc is undefined to consumers while out_valid = 0. It must not change while out_valid = 1 and out_ready = 0.
- Reset deassertion is assumed synchronised externally. The first accept is possible at the first edge after rst_n rises.

## Test plan
- Values: N = 0 → ANc = 0. N = 1 → ANc = 13. N = 252 → ANc = 3276 (0xCCC). N = 255 → ANc = 3315 (0xCF3). Each must appear 4 edges after the accept edge, with busy high for 4 cycles.
- Back-pressure: N = 100, out_ready held low for 10 cycles after out_valid rises.
  - Required: ANc = 1300 stable for all 10 cycles.
  - Required: in_ready = 0 for all 10 cycles.
  - Required: a single handshake when out_ready rises.
- Back-to-back: in_valid held high with N = 7, 8, 9 and out_ready held high.
  - Required: outputs 91, 104, 117 in order.
  - Required: the second word is accepted in the same cycle the first is drained, giving spacing of 5 cycles.
- Reset mid-operation: accept N = 200, assert rst_n low during the 2nd MUL cycle.
  - Required: out_valid never rises for that word.
  - Required: outputs return to reset values immediately.
  - Then N = 3 after release → 39.
- Protocol: in_valid pulsed with N = 50 during MUL of a prior N = 10.
  - Required: the pulse is ignored.
  - Required: output is 130 only.
- Random: 1000 random N in [0, 255] with random out_ready stalls. Every ANc must equal 13·N and satisfy ANc % 13 == 0. Every ANc must round-trip through the downstream decoder with no injected error, recovering the original N.
